// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor, diff = a - b - bin (mod 2^WIDTH).
// One bit is processed per clock, LSB first. States: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   begin an operation (honoured in IDLE only)
//   a, b    in   minuend / subtrahend, captured on the accepting edge
//   bin     in   borrow-in, captured on the accepting edge
//   busy    out  high whenever not IDLE
//   done    out  one-cycle pulse, diff/borrow newly valid
//   diff    out  result, held until the next completion or reset
//   borrow  out  borrow-out of the MSB stage
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

  // Operands shift right each RUN cycle, so bit i always sits at position 0;
  // the counter only decides when the last bit has been processed.
  always_comb begin
    w_ai      = r_a[0];
    w_bi      = r_b[0];
    w_d       = w_ai ^ w_bi ^ r_br;
    w_br_nxt  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // Result bits enter at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    w_acc_nxt = {w_d, r_acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_acc <= w_acc_nxt;
          if (r_cnt == C_LAST) begin
            r_diff   <= w_acc_nxt;
            r_borrow <= w_br_nxt;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub at WIDTH=4.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;

  int n_cmp;
  int n_err;
  int cyc;

  serial_sub #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and return in the cycle done is seen
  // (lat = edges after the accepting edge; 20 means it never came).
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       output int lat, output logic busy_acc);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    step();
    start = 1'b0;
    busy_acc = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 4'd5; b = 4'd3; bin = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (diff !== 4'd0) begin n_err++; $display("FAIL reset_diff got=%0d exp=0", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
    rst_n = 1'b1; start = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int   lat;
    logic ba;
    do_op(4'd5, 4'd3, 1'b0, lat, ba);
    n_cmp++; if (ba !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", ba); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_cmp++; if (diff !== 4'd2) begin n_err++; $display("FAIL basic_diff got=%0d exp=2", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL basic_borrow got=%b exp=0", borrow); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got=%b exp=0", busy); end
    step();
    step();
    n_cmp++; if (diff !== 4'd2) begin n_err++; $display("FAIL basic_hold got=%0d exp=2", diff); end
  endtask

  task automatic test_negative();
    int   lat;
    logic ba;
    do_op(4'd3, 4'd6, 1'b0, lat, ba);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL neg_timeout got=%0d exp=4", lat); end
    n_cmp++; if (diff !== 4'd13) begin n_err++; $display("FAIL neg_diff got=%0d exp=13", diff); end
    n_cmp++; if (borrow !== 1'b1) begin n_err++; $display("FAIL neg_borrow got=%b exp=1", borrow); end
    step();
    do_op(4'd0, 4'd0, 1'b1, lat, ba);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bin_timeout got=%0d exp=4", lat); end
    n_cmp++; if (diff !== 4'd15) begin n_err++; $display("FAIL bin_diff got=%0d exp=15", diff); end
    n_cmp++; if (borrow !== 1'b1) begin n_err++; $display("FAIL bin_borrow got=%b exp=1", borrow); end
    step();
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    a = 4'd15; b = 4'd15; bin = 1'b0; start = 1'b1;
    step();
    a = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    n_cmp++; if (diff !== 4'd0) begin n_err++; $display("FAIL ignore_diff got=%0d exp=0", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL ignore_borrow got=%b exp=0", borrow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle got=%b exp=0", busy); end
  endtask

  task automatic test_input_change();
    int lat;
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      step();
      lat++;
    end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL chg_timeout got=%0d exp=4", lat); end
    n_cmp++; if (diff !== 4'd5) begin n_err++; $display("FAIL chg_diff got=%0d exp=5", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL chg_borrow got=%b exp=0", borrow); end
    step();
  endtask

  task automatic test_reset_abort();
    int   ndone;
    int   lat;
    logic ba;
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (diff !== 4'd0) begin n_err++; $display("FAIL abort_diff got=%0d exp=0", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL abort_borrow got=%b exp=0", borrow); end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    do_op(4'd8, 4'd1, 1'b1, lat, ba);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL after_abort_timeout got=%0d exp=4", lat); end
    n_cmp++; if (diff !== 4'd6) begin n_err++; $display("FAIL after_abort_diff got=%0d exp=6", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL after_abort_borrow got=%b exp=0", borrow); end
    step();
  endtask

  task automatic test_back_to_back();
    int ea, eb, ebin, ed, eborrow, w, last;
    last = 0;
    a = 4'd0; b = 4'd0; bin = 1'b0; start = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      ea = (idx >> 5) & 15;
      eb = (idx >> 1) & 15;
      ebin = idx & 1;
      w = 0;
      do begin
        step();
        w++;
      end while (done !== 1'b1 && w < 20);
      if (w >= 20) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_timeout idx=%0d got=no_done exp=done", idx);
        break;
      end
      ed = (ea - eb - ebin) & 15;
      eborrow = (ea < eb + ebin) ? 1 : 0;
      n_cmp++;
      if ({borrow, diff} !== {1'(eborrow), 4'(ed)}) begin
        n_err++;
        $display("FAIL b2b_result a=%0d b=%0d bin=%0d got=%b/%0d exp=%0d/%0d",
                 ea, eb, ebin, borrow, diff, eborrow, ed);
      end
      if (idx > 0) begin
        n_cmp++;
        if (cyc - last !== 6) begin
          n_err++;
          $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", idx, cyc - last);
        end
      end
      last = cyc;
      if (idx < 511) begin
        a = 4'(((idx + 1) >> 5) & 15);
        b = 4'(((idx + 1) >> 1) & 15);
        bin = 1'((idx + 1) & 1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_negative();
    test_ignore_start();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 Port: bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.
REQ-009 Port: done  output  1  single-cycle pulse: diff and borrow are newly valid.
REQ-010 Port: diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-011 Port: borrow  output  1  borrow-out from the MSB stage.

Function
REQ-012 The block SHALL implement a bit-serial ripple-borrow subtractor, one bit per clock, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on an edge with start=1. The block SHALL then capture a, b and bin into internal registers, clear the bit counter, and load the running borrow with bin.
REQ-015 In RUN, each edge SHALL process bit i:
  - d_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - the counter increments by one.
REQ-016 On the edge that processes bit WIDTH-1, the block SHALL:
  - write the full result to diff and the final br' to borrow
  - move to DONE.
REQ-017 DONE -> IDLE unconditionally on the next edge; done SHALL be 1 only while in DONE.
REQ-018 Latency: when start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-019 diff and borrow SHALL change only on the completion edge, and SHALL hold their value until the next completion or reset.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing and no restart.
REQ-021 Changes on a, b or bin after the accepting edge SHALL NOT affect the result in progress.
REQ-022 Counter wrap: the bit counter SHALL be wide enough to hold WIDTH-1 and SHALL be cleared on entry to RUN; it SHALL never index beyond WIDTH-1.
REQ-023 Arithmetic: {borrow, diff} SHALL equal (2^WIDTH + a - b - bin) with borrow inverted, i.e. borrow=1 exactly when a < b + bin.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, diff=0 and borrow=0, and SHALL clear the internal operand, counter and borrow registers.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation without producing a done pulse; the result registers read 0.
REQ-026 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification (WIDTH=4)
REQ-027 Apply a=5, b=3, bin=0 with a start pulse at edge k. Required: busy=1 from k, done=1 after edge k+4, diff=2, borrow=0.
REQ-028 Apply a=3, b=6, bin=0. Required: diff=13, borrow=1. Then a=0, b=0, bin=1. Required: diff=15, borrow=1.
REQ-029 Apply a=15, b=15, bin=0, then drive start=1 with a=1 for the next 3 cycles. Required: diff=0, borrow=0, a single done pulse, and no second operation.
REQ-030 Start a=9, b=4, bin=0, then change a/b/bin every cycle during RUN. Required: diff=5, borrow=0.
REQ-031 Start a=7, b=2, then drive rst_n=0 at edge k+2. Required: busy=0, done never pulses, diff=0, borrow=0. A subsequent start with a=8, b=1, bin=1 gives diff=6, borrow=0.
REQ-032 Run an exhaustive loop over a, b and bin with back-to-back starts. Required: every result matches REQ-023 and done spacing is exactly 6 cycles.
